// File: rtl/color_xform.sv
// Colour-space converter between YUV422 component streams and packed RGB pixels,
// with a small first-word-fall-through output FIFO.
module color_xform #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_mode,
  input  logic            in_valid,
  input  logic [3*DW-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [3*DW-1:0] out_data,
  input  logic            out_ready,
  output logic            busy
);

  localparam int W  = DW + 8;
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] C0 = 3'd0;
  localparam logic [2:0] C1 = 3'd1;
  localparam logic [2:0] C2 = 3'd2;
  localparam logic [2:0] C3 = 3'd3;
  localparam logic [2:0] E0 = 3'd4;
  localparam logic [2:0] E1 = 3'd5;
  localparam logic [2:0] E2 = 3'd6;
  localparam logic [2:0] E3 = 3'd7;

  localparam logic signed [W-1:0] RND   = {{(W-3){1'b0}}, 3'b100};
  localparam logic signed [W-1:0] ZERO  = {W{1'b0}};
  localparam logic signed [W-1:0] MAX_U = {{(W-DW){1'b0}}, {DW{1'b1}}};
  localparam logic signed [W-1:0] MAX_S = {{(W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_S = {{(W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [AW:0]         FULL_CNT = (AW+1)'(DEPTH);

  function automatic logic signed [W-1:0] ext_u(input logic [DW-1:0] x);
    return $signed({{(W-DW){1'b0}}, x});
  endfunction

  function automatic logic signed [W-1:0] ext_s(input logic [DW-1:0] x);
    return $signed({{(W-DW){x[DW-1]}}, x});
  endfunction

  // Round-to-nearest divide by 8, then saturate to the unsigned or signed component range
  function automatic logic [DW-1:0] clip_u(input logic signed [W-1:0] sum);
    logic signed [W-1:0] r;
    r = (sum + RND) >>> 3'd3;
    if (r < ZERO)       return {DW{1'b0}};
    else if (r > MAX_U) return {DW{1'b1}};
    else                return r[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] clip_s(input logic signed [W-1:0] sum);
    logic signed [W-1:0] r;
    r = (sum + RND) >>> 3'd3;
    if (r > MAX_S)      return {1'b0, {(DW-1){1'b1}}};
    else if (r < MIN_S) return {1'b1, {(DW-1){1'b0}}};
    else                return r[DW-1:0];
  endfunction

  function automatic logic [3*DW-1:0] yuv2rgb(input logic [DW-1:0] y,
                                              input logic [DW-1:0] u,
                                              input logic [DW-1:0] v);
    logic signed [W-1:0] ys, us, vs, r, g, b;
    ys = ext_u(y);
    us = ext_s(u);
    vs = ext_s(v);
    r  = (ys <<< 3'd3) + (vs <<< 3'd3) + (vs <<< 3'd2) + vs;
    g  = (ys <<< 3'd3) - (us <<< 3'd1) - (vs <<< 3'd2) - (vs <<< 3'd1);
    b  = (ys <<< 3'd3) + (us <<< 3'd4);
    return {clip_u(r), clip_u(g), clip_u(b)};
  endfunction

  function automatic logic [DW-1:0] luma(input logic [3*DW-1:0] p);
    logic signed [W-1:0] r, g, b;
    r = ext_u(p[3*DW-1:2*DW]);
    g = ext_u(p[2*DW-1:DW]);
    b = ext_u(p[DW-1:0]);
    return clip_u((r <<< 3'd1) + (g <<< 3'd2) + g + b);
  endfunction

  function automatic logic [DW-1:0] chroma_u(input logic [3*DW-1:0] p);
    logic signed [W-1:0] r, g, b;
    r = ext_u(p[3*DW-1:2*DW]);
    g = ext_u(p[2*DW-1:DW]);
    b = ext_u(p[DW-1:0]);
    return clip_s((b <<< 3'd1) + b - r - (g <<< 3'd1));
  endfunction

  function automatic logic [DW-1:0] chroma_v(input logic [3*DW-1:0] p);
    logic signed [W-1:0] r, g, b;
    r = ext_u(p[3*DW-1:2*DW]);
    g = ext_u(p[2*DW-1:DW]);
    b = ext_u(p[DW-1:0]);
    return clip_s((r <<< 3'd2) - (g <<< 3'd1) - g - b);
  endfunction

  logic [2:0]      state_r, state_nxt_s;
  logic            mode_q;
  logic [DW-1:0]   u_r, y1_r, v_r, y2_r;
  logic [3*DW-1:0] p1_r;
  logic [3*DW-1:0] mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [AW:0]     count_r;
  logic            full_s, xfer_s, pop_s, push_s, do_push_s;
  logic [3*DW-1:0] push_data_s;

  assign full_s    = (count_r == FULL_CNT);
  assign in_ready  = !state_r[2] && !full_s;
  assign busy      = !in_ready;
  assign xfer_s    = in_valid && in_ready;
  assign out_valid = (count_r != {(AW+1){1'b0}});
  assign out_data  = out_valid ? mem_r[rd_ptr_r] : {(3*DW){1'b0}};
  assign pop_s     = out_valid && out_ready;
  assign do_push_s = push_s && (!full_s || pop_s);

  // Next-state and FIFO push selection; mode-0 pixels use the live V/Y2 input
  always_comb begin
    state_nxt_s = state_r;
    push_s      = 1'b0;
    push_data_s = {(3*DW){1'b0}};
    case (state_r)
      C0: begin
        if (xfer_s) state_nxt_s = C1;
        else        state_nxt_s = state_r;
      end
      C1: begin
        if (xfer_s) state_nxt_s = mode_q ? E0 : C2;
        else        state_nxt_s = state_r;
      end
      C2: begin
        if (xfer_s) begin
          push_s      = 1'b1;
          push_data_s = yuv2rgb(y1_r, u_r, in_data[DW-1:0]);
          state_nxt_s = C3;
        end else begin
          state_nxt_s = state_r;
        end
      end
      C3: begin
        if (xfer_s) begin
          push_s      = 1'b1;
          push_data_s = yuv2rgb(in_data[DW-1:0], u_r, v_r);
          state_nxt_s = C0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      E0, E1, E2, E3: begin
        if (!full_s) begin
          push_s = 1'b1;
          case (state_r)
            E0:      push_data_s = {{(2*DW){1'b0}}, u_r};
            E1:      push_data_s = {{(2*DW){1'b0}}, y1_r};
            E2:      push_data_s = {{(2*DW){1'b0}}, v_r};
            default: push_data_s = {{(2*DW){1'b0}}, y2_r};
          endcase
          state_nxt_s = (state_r == E3) ? C0 : state_r + 3'd1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = C0;
    endcase
  end

  // Group state, latched mode and component registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= C0;
      mode_q  <= 1'b0;
      u_r     <= {DW{1'b0}};
      y1_r    <= {DW{1'b0}};
      v_r     <= {DW{1'b0}};
      y2_r    <= {DW{1'b0}};
      p1_r    <= {(3*DW){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        C0: if (xfer_s) begin
          mode_q <= op_mode;
          if (op_mode) p1_r <= in_data;
          else         u_r  <= in_data[DW-1:0];
        end
        C1: if (xfer_s) begin
          if (mode_q) begin
            u_r  <= chroma_u(p1_r);
            y1_r <= luma(p1_r);
            v_r  <= chroma_v(p1_r);
            y2_r <= luma(in_data);
          end else begin
            y1_r <= in_data[DW-1:0];
          end
        end
        C2: if (xfer_s) v_r <= in_data[DW-1:0];
        default: ;
      endcase
    end
  end

  // Output FIFO storage and pointers; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {(3*DW){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_color_xform.sv
// Self-checking bench for color_xform: directed vectors plus randomized groups
// compared against an arithmetic reference model through an output scoreboard.
module tb_color_xform;

  logic        clk = 1'b0;
  logic        reset, op_mode, in_valid, in_ready, out_valid, out_ready, busy;
  logic [23:0] in_data, out_data;
  logic        rand_bp = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];

  color_xform #(.DW(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .op_mode(op_mode), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record every popped word, sampled mid-cycle
  always @(negedge clk)
    if (!reset && out_valid && out_ready) got_q.push_back(out_data);

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic m, input logic [23:0] d);
    int n;
    n = 0;
    op_mode  = m;
    in_data  = d;
    in_valid = 1'b1;
    if (rand_bp) out_ready = 1'($urandom_range(1, 0));
    while (!in_ready && n < 100) begin
      tick();
      n++;
      if (rand_bp) out_ready = 1'($urandom_range(1, 0));
    end
    if (n >= 100) chk("send_timeout", 24'(n), 24'd0);
    tick();
    in_valid = 1'b0;
    in_data  = 24'($urandom());
  endtask

  function automatic int s8(input logic [7:0] b);
    return b[7] ? int'(b) - 256 : int'(b);
  endfunction

  function automatic int clampi(input int x, input int lo, input int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  function automatic int rnd3(input int s);
    return (s + 4) >>> 3;
  endfunction

  function automatic logic [23:0] m_rgb(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
    int yy, uu, vv, r, g, b;
    yy = int'(y);
    uu = s8(u);
    vv = s8(v);
    r = clampi(rnd3(8*yy + 13*vv), 0, 255);
    g = clampi(rnd3(8*yy - 2*uu - 6*vv), 0, 255);
    b = clampi(rnd3(8*yy + 16*uu), 0, 255);
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic m_yuv_words(input logic [23:0] p1, input logic [23:0] p2);
    int r1, g1, b1, r2, g2, b2, y1, y2, u, v;
    r1 = int'(p1[23:16]); g1 = int'(p1[15:8]); b1 = int'(p1[7:0]);
    r2 = int'(p2[23:16]); g2 = int'(p2[15:8]); b2 = int'(p2[7:0]);
    y1 = clampi(rnd3(2*r1 + 5*g1 + b1), 0, 255);
    y2 = clampi(rnd3(2*r2 + 5*g2 + b2), 0, 255);
    u  = clampi(rnd3(-r1 - 2*g1 + 3*b1), -128, 127);
    v  = clampi(rnd3(4*r1 - 3*g1 - b1), -128, 127);
    exp_q.push_back({16'h0, 8'(u)});
    exp_q.push_back({16'h0, 8'(y1)});
    exp_q.push_back({16'h0, 8'(v)});
    exp_q.push_back({16'h0, 8'(y2)});
  endtask

  task automatic drain(input string tag);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) begin
      tick();
      if (!out_valid) chk({tag, "_idle_zero"}, out_data, 24'h0);
    end
    chk({tag, "_empty"}, {23'h0, out_valid}, 24'h0);
    chk({tag, "_count"}, 24'(got_q.size()), 24'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_data"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [23:0] a, b, c, d;
    logic [23:0] t038 [4];
    logic        m;

    reset = 1'b1; in_valid = 1'b0; in_data = 24'h0; op_mode = 1'b0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_out_valid", {23'h0, out_valid}, 24'h0);
    chk("rst_out_data", out_data, 24'h0);
    chk("rst_in_ready", {23'h0, in_ready}, 24'h1);
    chk("rst_busy", {23'h0, busy}, 24'h0);

    // Mode 0 basic grey pixels, one cycle after V and Y2
    send(1'b0, 24'h000000); send(1'b0, 24'h000064); send(1'b0, 24'h000000);
    chk("m0_v_latency", {23'h0, out_valid}, 24'h1);
    chk("m0_pix1", out_data, 24'h646464);
    send(1'b0, 24'h0000C8);
    chk("m0_pix2", out_data, 24'hC8C8C8);
    exp_q.push_back(24'h646464); exp_q.push_back(24'hC8C8C8);
    drain("m0_basic");

    // Mode 0 saturation at both ends
    send(1'b0, 24'h00007F); send(1'b0, 24'h0000FF); send(1'b0, 24'h00007F);
    chk("m0_sat_hi", out_data, 24'hFF80FF);
    send(1'b0, 24'h000010);
    exp_q.push_back(24'hFF80FF); exp_q.push_back(m_rgb(8'h10, 8'h7F, 8'h7F));
    send(1'b0, 24'h000080); send(1'b0, 24'h000000); send(1'b0, 24'h000080);
    chk("m0_sat_lo", out_data, 24'h008000);
    send(1'b0, 24'hAB0020);
    exp_q.push_back(24'h008000); exp_q.push_back(m_rgb(8'h20, 8'h80, 8'h80));
    drain("m0_sat");

    // Mode 1 rounding and emit timing
    t038[0] = 24'h000060; t038[1] = 24'h000020; t038[2] = 24'h0000E0; t038[3] = 24'h0000FF;
    send(1'b1, 24'h0000FF); send(1'b1, 24'hFFFFFF);
    chk("m1_e0_ready", {23'h0, in_ready}, 24'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("m1_emit", out_data, t038[i]);
      if (i < 3) chk("m1_emit_ready", {23'h0, in_ready}, 24'h0);
      exp_q.push_back(t038[i]);
    end
    drain("m1_round");

    // Backpressure fills the FIFO and blocks input until one pop
    out_ready = 1'b0;
    a = 24'($urandom()); b = 24'($urandom());
    send(1'b1, a); send(1'b1, b);
    m_yuv_words(a, b);
    repeat (4) tick();
    chk("bp_full_ready", {23'h0, in_ready}, 24'h0);
    chk("bp_full_busy", {23'h0, busy}, 24'h1);
    repeat (3) tick();
    chk("bp_hold_ready", {23'h0, in_ready}, 24'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_pop_ready", {23'h0, in_ready}, 24'h1);
    drain("bp");

    // op_mode changes after U are ignored until the group ends
    a = 24'($urandom()); b = 24'($urandom()); c = 24'($urandom()); d = 24'($urandom());
    send(1'b0, a); send(1'b1, b); send(1'b1, c); send(1'b1, d);
    exp_q.push_back(m_rgb(b[7:0], a[7:0], c[7:0]));
    exp_q.push_back(m_rgb(d[7:0], a[7:0], c[7:0]));
    a = 24'($urandom()); b = 24'($urandom());
    send(1'b1, a); send(1'b1, b);
    m_yuv_words(a, b);
    drain("mode_switch");

    // Reset during emit discards everything
    a = 24'($urandom()); b = 24'($urandom());
    send(1'b1, a); send(1'b1, b);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_e1_out_valid", {23'h0, out_valid}, 24'h0);
    chk("rst_e1_in_ready", {23'h0, in_ready}, 24'h1);
    chk("rst_e1_out_data", out_data, 24'h0);
    got_q.delete(); exp_q.delete();
    a = 24'($urandom()); b = 24'($urandom()); c = 24'($urandom()); d = 24'($urandom());
    send(1'b0, a); send(1'b0, b); send(1'b0, c); send(1'b0, d);
    exp_q.push_back(m_rgb(b[7:0], a[7:0], c[7:0]));
    exp_q.push_back(m_rgb(d[7:0], a[7:0], c[7:0]));
    drain("after_reset");

    // Randomized groups with random backpressure and idle gaps
    rand_bp = 1'b1;
    repeat (40) begin
      m = 1'($urandom_range(1, 0));
      a = 24'($urandom()); b = 24'($urandom()); c = 24'($urandom()); d = 24'($urandom());
      if (m) begin
        send(1'b1, a); send(1'b1, b);
        m_yuv_words(a, b);
      end else begin
        send(1'b0, a);
        send(1'($urandom_range(1, 0)), b);
        send(1'($urandom_range(1, 0)), c);
        send(1'($urandom_range(1, 0)), d);
        exp_q.push_back(m_rgb(b[7:0], a[7:0], c[7:0]));
        exp_q.push_back(m_rgb(d[7:0], a[7:0], c[7:0]));
      end
      repeat ($urandom_range(2, 0)) begin
        out_ready = 1'($urandom_range(1, 0));
        tick();
      end
    end
    rand_bp = 1'b0;
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
